fixed_clock_reset_sequencer: RTL



---
 rtl/fixed_clock_reset_sequencer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fixed_clock_reset_sequencer.sv
// Reset/clock-enable sequencer for the fixed clock broadcast tree: staggered boot-time
// release of every domain reset, then lowest-index-first servicing of software re-reset requests.
module fixed_clock_reset_sequencer #(
  parameter int NUM_OUT        = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4,
  parameter int CNT_W          = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_OUT-1:0] sw_rst_req,
  output logic [NUM_OUT-1:0] sw_rst_ack,
  output logic [NUM_OUT-1:0] out_reset,
  output logic [NUM_OUT-1:0] out_clk_en,
  output logic               all_released,
  output logic               busy
);

  localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_OUT - 1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_STAG,
    S_RUN,
    S_DOM
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NUM_OUT-1:0]   rst_q, rst_d;
  logic [NUM_OUT-1:0]   clk_en_q;
  logic [NUM_OUT-1:0]   ack_q, ack_d;
  logic                 busy_q, busy_d;

  logic [NUM_OUT-1:0]   eligible;
  logic                 grant;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W-1:0]     idx_inc;

  // Lowest eligible index wins; a domain whose ack is still up is not eligible.
  always_comb begin
    eligible  = sw_rst_req & ~ack_q;
    grant     = 1'b0;
    grant_idx = '0;
    for (int k = NUM_OUT - 1; k >= 0; k--) begin
      if (eligible[k]) begin
        grant     = 1'b1;
        grant_idx = IDX_W'(k);
      end
    end
  end

  assign idx_inc = idx_q + IDX_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    ack_d   = ack_q & sw_rst_req;
    case (state_q)
      S_HOLD: begin
        // Counting only begins once the clock enables are up (edge 1).
        if (clk_en_q[0]) begin
          if (cnt_q == HOLD_LAST) begin
            cnt_d    = '0;
            rst_d[0] = 1'b0;
            idx_d    = '0;
            state_d  = (NUM_OUT == 1) ? S_RUN : S_STAG;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_STAG: begin
        if (cnt_q == STAG_LAST) begin
          cnt_d          = '0;
          rst_d[idx_inc] = 1'b0;
          idx_d          = idx_inc;
          if (idx_inc == IDX_LAST) state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (grant) begin
          rst_d[grant_idx] = 1'b1;
          idx_d            = grant_idx;
          cnt_d            = '0;
          state_d          = S_DOM;
        end
      end
      S_DOM: begin
        // Ack is set even if the request already dropped, so it pulses at least once.
        if (cnt_q == HOLD_LAST) begin
          cnt_d        = '0;
          rst_d[idx_q] = 1'b0;
          ack_d[idx_q] = 1'b1;
          state_d      = S_RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_HOLD;
    endcase
    busy_d = (state_d != S_RUN);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_HOLD;
      cnt_q    <= '0;
      idx_q    <= '0;
      rst_q    <= '1;
      clk_en_q <= '0;
      ack_q    <= '0;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      rst_q    <= rst_d;
      clk_en_q <= '1;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
    end
  end

  assign out_reset    = rst_q;
  assign out_clk_en   = clk_en_q;
  assign sw_rst_ack   = ack_q;
  assign busy         = busy_q;
  assign all_released = ~|rst_q;

endmodule
